// File: rtl/uart_rx_fifo.sv
// Byte FIFO between a UART receiver and a consumer: circular buffer with
// occupancy counter, sticky overflow flag and an occupancy-threshold interrupt.
module uart_rx_fifo #(
   parameter int DEPTH     = 16,
   parameter int ADDR_W    = 4,
   parameter int IRQ_LEVEL = 8
) (
   input  logic              i_Clock,
   input  logic              i_Rst_n,
   input  logic              i_Rx_DV,
   input  logic [7:0]        i_Rx_Byte,
   input  logic              i_Rd_En,
   input  logic              i_Clr_Ovf,
   output logic [7:0]        o_Rd_Data,
   output logic              o_Rd_Valid,
   output logic [ADDR_W:0]   o_Count,
   output logic              o_Empty,
   output logic              o_Full,
   output logic              o_Overflow,
   output logic              o_Irq
);

   localparam logic [ADDR_W:0]   FULL_CNT = (ADDR_W+1)'(DEPTH);
   localparam logic [ADDR_W:0]   IRQ_CNT  = (ADDR_W+1)'(IRQ_LEVEL);
   localparam logic [ADDR_W:0]   CNT_ONE  = (ADDR_W+1)'(1);
   localparam logic [ADDR_W-1:0] PTR_ONE  = ADDR_W'(1);

   logic [7:0]        mem [DEPTH];
   logic [ADDR_W-1:0] wr_ptr;
   logic [ADDR_W-1:0] rd_ptr;
   logic [ADDR_W:0]   count;
   logic              empty;
   logic              full;
   logic              pop_ok;
   logic              wr_ok;
   logic              ovf_evt;
   logic              rd_valid;
   logic [7:0]        rd_data;
   logic              overflow;

   // A pop frees a slot in the same cycle, so a full FIFO still accepts a write
   // when it is popped; an empty FIFO never bypasses the incoming byte.
   always_comb begin
      empty   = (count == '0);
      full    = (count == FULL_CNT);
      pop_ok  = i_Rd_En && !empty;
      wr_ok   = i_Rx_DV && (!full || pop_ok);
      ovf_evt = i_Rx_DV && full && !pop_ok;
   end

   always_ff @(posedge i_Clock) begin
      if (i_Rst_n && wr_ok) begin
         mem[wr_ptr] <= i_Rx_Byte;
      end
   end

   always_ff @(posedge i_Clock) begin
      if (!i_Rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (wr_ok) begin
            wr_ptr <= wr_ptr + PTR_ONE;
         end
         if (pop_ok) begin
            rd_ptr <= rd_ptr + PTR_ONE;
         end
         case ({wr_ok, pop_ok})
            2'b10:   count <= count + CNT_ONE;
            2'b01:   count <= count - CNT_ONE;
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge i_Clock) begin
      if (!i_Rst_n) begin
         rd_data  <= 8'h00;
         rd_valid <= 1'b0;
      end else begin
         rd_valid <= pop_ok;
         if (pop_ok) begin
            rd_data <= mem[rd_ptr];
         end
      end
   end

   // A dropped byte in the same cycle as a clear request keeps the flag set.
   always_ff @(posedge i_Clock) begin
      if (!i_Rst_n) begin
         overflow <= 1'b0;
      end else if (ovf_evt) begin
         overflow <= 1'b1;
      end else if (i_Clr_Ovf) begin
         overflow <= 1'b0;
      end
   end

   assign o_Rd_Data  = rd_data;
   assign o_Rd_Valid = rd_valid;
   assign o_Count    = count;
   assign o_Empty    = empty;
   assign o_Full     = full;
   assign o_Overflow = overflow;
   assign o_Irq      = (count >= IRQ_CNT);

endmodule

// File: doc/uart_rx_fifo.md
UART_RX_FIFO -- requirements
Module: uart_rx_fifo

Interface
REQ-001 The block SHALL have parameter DEPTH, default 16, giving the number of byte entries (power of 2, 2..256).
REQ-002 The block SHALL have parameter ADDR_W, default 4, equal to log2(DEPTH).
REQ-003 The block SHALL have parameter IRQ_LEVEL, default 8, giving the occupancy threshold for o_Irq (1..DEPTH).
REQ-004 i_Clock  input  1  sole clock; all state updates on the rising edge.
REQ-005 i_Rst_n  input  1  reset, synchronous, active-low.
REQ-006 i_Rx_DV  input  1  one-cycle strobe from the UART receiver: received byte valid.
REQ-007 i_Rx_Byte  input  8  received byte; sampled only when i_Rx_DV=1.
REQ-008 i_Rd_En  input  1  consumer pop request, one per cycle.
REQ-009 o_Rd_Data  output  8  last popped byte, registered.
REQ-010 o_Rd_Valid  output  1  one-cycle strobe: o_Rd_Data updated by a pop.
REQ-011 o_Count  output  ADDR_W+1  current occupancy, 0..DEPTH.
REQ-012 o_Empty / o_Full  output  1 each  occupancy==0 / occupancy==DEPTH.
REQ-013 o_Overflow  output  1  sticky flag: byte dropped because FIFO was full.
REQ-014 i_Clr_Ovf  input  1  clears o_Overflow.
REQ-015 o_Irq  output  1  occupancy >= IRQ_LEVEL.

Function
REQ-016 Storage SHALL be a circular buffer with write pointer, read pointer (ADDR_W bits, wrap DEPTH-1 -> 0) and a registered occupancy counter.
REQ-017 On i_Rx_DV=1 with FIFO not full, the byte SHALL be written at the write pointer and the pointer incremented; occupancy visible on o_Count the next cycle.
REQ-018 On i_Rx_DV=1 with FIFO full and no pop that cycle, the byte SHALL be discarded, contents unchanged, o_Overflow set the next cycle.
REQ-019 On i_Rd_En=1 with FIFO not empty, the entry at the read pointer SHALL appear on o_Rd_Data the next cycle with o_Rd_Valid=1 for exactly that cycle; read pointer incremented.
REQ-020 i_Rd_En=1 while empty SHALL be ignored: no pointer change, o_Rd_Valid=0, o_Rd_Data holds.
REQ-021 o_Rd_Data SHALL hold its value between pops.
REQ-022 Simultaneous write and pop while full: both SHALL occur, occupancy unchanged, no overflow.
REQ-023 Simultaneous write and pop while empty: write SHALL occur, pop ignored (no bypass), occupancy becomes 1.
REQ-024 Simultaneous write and pop, neither full nor empty: both occur, occupancy unchanged.
REQ-025 o_Empty, o_Full, o_Irq SHALL be decoded from the registered occupancy counter, no added latency relative to o_Count.
REQ-026 i_Clr_Ovf=1 SHALL clear o_Overflow the next cycle; a same-cycle overflow event SHALL win (flag stays 1).
REQ-027 Counters SHALL never exceed DEPTH nor underflow below 0.

Reset
REQ-028 While i_Rst_n=0 at a clock edge: pointers=0, occupancy=0, o_Rd_Data=8'h00, o_Rd_Valid=0, o_Overflow=0; hence o_Empty=1, o_Full=0, o_Irq=0.
REQ-029 Storage array contents SHALL not be reset; reset mid-operation SHALL discard all buffered bytes and any in-flight write or pop of that cycle.
REQ-030 Reset SHALL have priority over all other inputs.

Verification
REQ-031 Write 8'hA5, 8'h3C, then pop twice -> o_Rd_Data 8'hA5 then 8'h3C, each with one-cycle o_Rd_Valid one cycle after i_Rd_En; o_Empty=1 afterwards.
REQ-032 Write 17 bytes 8'h00..8'h10 with DEPTH=16 -> o_Full=1, o_Count=16, o_Overflow=1; 16 pops return 8'h00..8'h0F; 8'h10 lost.
REQ-033 Full FIFO, same-cycle write 8'hEE and pop -> pop returns oldest byte, o_Count stays 16, o_Overflow stays 0; 8'hEE read last.
REQ-034 Pop when empty -> o_Rd_Valid stays 0, o_Rd_Data unchanged, o_Count stays 0.
REQ-035 Overflow set, assert i_Clr_Ovf with no write -> o_Overflow=0 next cycle; repeat with concurrent overflowing write -> o_Overflow stays 1.
REQ-036 Write 5 bytes, wrap pointers by 20 write/pop pairs, assert i_Rst_n=0 one cycle -> o_Count=0, o_Empty=1, o_Irq=0, o_Rd_Data=8'h00; o_Irq asserts when o_Count reaches 8.
